// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment digit multiplexer:
// sequencer states, hex-to-segment table, idle constants and a one-hot test.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_DEAD    = 2'd1,
        ST_INVALID = 2'd2
    } seq_state_e;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All anodes off (active-low).
    localparam logic [3:0] AN_IDLE = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, index = hex value (F first, 0 last).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // True when exactly one bit of the strobe is set.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/seg7_sync.sv
// Multi-flop synchroniser for a bus of independent level signals.
// STAGES flops deep, asynchronous active-low reset to zero.
module seg7_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift the input one stage further down the chain each cycle.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/seg7_digit_mux.sv
// Four-digit common-anode seven-segment multiplexer driven by an external
// one-hot ring-counter strobe. The strobe is synchronised, every digit change
// is separated by a blanked dead time, and new display data is taken only at
// the frame boundary (strobe moving to digit 3) under a load/ack handshake.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_digit_mux
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_CYC    = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  dig_sel,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        sel_err
);

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC);

    logic [3:0]  sel_s;
    logic [3:0]  sel_p_q;
    logic        sel_valid;
    logic        sel_change;
    logic        frame_bnd;

    logic [15:0] pend_q, pend_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] shown_q, shown_d;
    logic [3:0]  shown_dp_q, shown_dp_d;
    logic        ack_q, ack_d;

    seq_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        err_q, err_d;
    logic        seen_q, seen_d;

    logic [1:0]  dig_idx;
    logic [3:0]  dig_nib;
    logic        dig_blank;
    logic [6:0]  dig_seg;
    logic        dig_dp_n;

    seg7_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (4)
    ) u_sync (
        .clk   (clk),
        .rst_n (clr_n),
        .d     (dig_sel),
        .q     (sel_s)
    );

    assign sel_valid  = is_onehot(sel_s);
    assign sel_change = sel_valid && (sel_s != sel_p_q);
    // Only a step from another valid digit counts; recovery from a bad strobe does not.
    assign frame_bnd  = (sel_s == 4'b1000) && (sel_p_q != 4'b1000) && is_onehot(sel_p_q);

    // Pending/shown data handshake: apply old pending at the boundary, then take any new load.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pend_d     = pend_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        shown_d    = shown_q;
        shown_dp_d = shown_dp_q;
        ack_d      = 1'b0;
        if (frame_bnd && pend_vld_q) begin
            shown_d    = pend_q;
            shown_dp_d = pend_dp_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end
        if (load) begin
            pend_d     = data_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Decode the digit currently selected by the synchronised strobe.
    always_comb begin
        unique case (sel_s)
            4'b1000: dig_idx = 2'd3;
            4'b0100: dig_idx = 2'd2;
            4'b0010: dig_idx = 2'd1;
            default: dig_idx = 2'd0;
        endcase
        dig_nib  = shown_d[{dig_idx, 2'b00} +: 4];
        dig_dp_n = ~shown_dp_d[dig_idx];
`ifdef SEG7_LZ_BLANK_EN
        unique case (dig_idx)
            2'd3:    dig_blank = (shown_d[15:12] == 4'h0);
            2'd2:    dig_blank = (shown_d[15:8]  == 8'h00);
            2'd1:    dig_blank = (shown_d[15:4]  == 12'h000);
            default: dig_blank = 1'b0;
        endcase
`else
        dig_blank = 1'b0;
`endif
        dig_seg = dig_blank ? SEG_BLANK : SEG_TABLE[dig_nib];
    end

    // Sequencer next state: scan, blank for the dead time on each change, or lock out on a bad strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        err_d   = err_q;
        seen_d  = seen_q | sel_valid;
        if (!sel_valid) begin
            // All-zero while the synchroniser is still filling after reset is not an error.
            if (seen_q || (sel_s != 4'b0000)) begin
                state_d = ST_INVALID;
                err_d   = 1'b1;
            end
            an_d  = AN_IDLE;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_SCAN, ST_INVALID: begin
                    if (sel_change || (state_q == ST_INVALID)) begin
                        if (DEAD_CYC == 0) begin
                            state_d = ST_SCAN;
                            an_d    = ~sel_s;
                            seg_d   = dig_seg;
                            dp_d    = dig_dp_n;
                        end else begin
                            state_d = ST_DEAD;
                            cnt_d   = DEAD_LOAD;
                            an_d    = AN_IDLE;
                            seg_d   = SEG_BLANK;
                            dp_d    = 1'b1;
                        end
                    end else begin
                        an_d  = ~sel_s;
                        seg_d = dig_seg;
                        dp_d  = dig_dp_n;
                    end
                end
                ST_DEAD: begin
                    if (sel_change) begin
                        cnt_d = DEAD_LOAD;
                    end else if (cnt_q <= 4'd1) begin
                        state_d = ST_SCAN;
                        an_d    = ~sel_s;
                        seg_d   = dig_seg;
                        dp_d    = dig_dp_n;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_INVALID;
                    an_d    = AN_IDLE;
                    seg_d   = SEG_BLANK;
                    dp_d    = 1'b1;
                end
            endcase
        end
    end

    // Data path registers: previous strobe, pending and shown display data, ack pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sel_p_q    <= 4'b0000;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            shown_q    <= '0;
            shown_dp_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            sel_p_q    <= sel_s;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            shown_q    <= shown_d;
            shown_dp_q <= shown_dp_d;
            ack_q      <= ack_d;
        end
    end

    // Sequencer state and registered display outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_INVALID;
            cnt_q   <= '0;
            an_q    <= AN_IDLE;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
        end
    end

    assign load_ack = ack_q;
    assign an_n     = an_q;
    assign seg_n    = seg_q;
    assign dp_n     = dp_q;
    assign sel_err  = err_q;

endmodule

// File: tb/tb_seg7_digit_mux.sv
// Directed testbench for seg7_digit_mux with default parameters: decode table
// over four loaded words, dead-time timing, load coalescing, invalid strobe
// recovery, reset mid-dead-time and leading-zero behaviour.
module tb_seg7_digit_mux;

    logic        clk;
    logic        clr_n;
    logic [3:0]  dig_sel;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        sel_err;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int a0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  sel;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp_n;
    } vec_t;

    vec_t vec [16];
    logic [3:0] prev_an;

    seg7_digit_mux dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .dig_sel  (dig_sel),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .load     (load),
        .load_ack (load_ack),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ack pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (load_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
        data_in = d;
        dp_in   = dp;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Change the strobe and check the anode timing: old digit for 2 samples,
    // blank for exactly 2, new anode on the 5th; then let it settle.
    task automatic do_strobe(input logic [3:0] sel, input logic [3:0] old_an,
                             input logic [3:0] new_an, input logic exp_ack, input string tag);
        dig_sel = sel;
        repeat (2) @(negedge clk);
        check($sformatf("%s an_before", tag), 32'(an_n), 32'(old_an));
        @(negedge clk);
        check($sformatf("%s an_dead1", tag), 32'(an_n), 32'hF);
        check($sformatf("%s seg_dead", tag), 32'(seg_n), 32'h7F);
        check($sformatf("%s ack", tag), 32'(load_ack), 32'(exp_ack));
        @(negedge clk);
        check($sformatf("%s an_dead2", tag), 32'(an_n), 32'hF);
        @(negedge clk);
        check($sformatf("%s an_new", tag), 32'(an_n), 32'(new_an));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{16'h1234, 4'b0101, 4'b1000, 4'h7, 7'h79, 1'b1};
        vec[1]  = '{16'h1234, 4'b0101, 4'b0100, 4'hB, 7'h24, 1'b0};
        vec[2]  = '{16'h1234, 4'b0101, 4'b0010, 4'hD, 7'h30, 1'b1};
        vec[3]  = '{16'h1234, 4'b0101, 4'b0001, 4'hE, 7'h19, 1'b0};
        vec[4]  = '{16'h5678, 4'b1000, 4'b1000, 4'h7, 7'h12, 1'b0};
        vec[5]  = '{16'h5678, 4'b1000, 4'b0100, 4'hB, 7'h02, 1'b1};
        vec[6]  = '{16'h5678, 4'b1000, 4'b0010, 4'hD, 7'h78, 1'b1};
        vec[7]  = '{16'h5678, 4'b1000, 4'b0001, 4'hE, 7'h00, 1'b1};
        vec[8]  = '{16'h9ABC, 4'b0000, 4'b1000, 4'h7, 7'h10, 1'b1};
        vec[9]  = '{16'h9ABC, 4'b0000, 4'b0100, 4'hB, 7'h08, 1'b1};
        vec[10] = '{16'h9ABC, 4'b0000, 4'b0010, 4'hD, 7'h03, 1'b1};
        vec[11] = '{16'h9ABC, 4'b0000, 4'b0001, 4'hE, 7'h46, 1'b1};
        vec[12] = '{16'hDEF0, 4'b1111, 4'b1000, 4'h7, 7'h21, 1'b0};
        vec[13] = '{16'hDEF0, 4'b1111, 4'b0100, 4'hB, 7'h06, 1'b0};
        vec[14] = '{16'hDEF0, 4'b1111, 4'b0010, 4'hD, 7'h0E, 1'b0};
        vec[15] = '{16'hDEF0, 4'b1111, 4'b0001, 4'hE, 7'h40, 1'b0};

        clr_n   = 1'b0;
        dig_sel = 4'b0001;
        data_in = '0;
        dp_in   = '0;
        load    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst an_n", 32'(an_n), 32'hF);
        check("rst seg_n", 32'(seg_n), 32'h7F);
        check("rst dp_n", 32'(dp_n), 32'h1);
        check("rst load_ack", 32'(load_ack), 32'h0);
        check("rst sel_err", 32'(sel_err), 32'h0);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        check("boot an_n", 32'(an_n), 32'hE);
        check("boot seg_n zero", 32'(seg_n), 32'h40);
        check("boot dp_n", 32'(dp_n), 32'h1);
        check("boot sel_err", 32'(sel_err), 32'h0);

        // Decode table: each group loads a word mid-frame, then scans a full frame.
        prev_an = 4'hE;
        a0 = ack_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) load_word(vec[i].data, vec[i].dp);
            do_strobe(vec[i].sel, prev_an, vec[i].exp_an, (i % 4 == 0), $sformatf("vec%0d", i));
            check($sformatf("vec%0d seg_n", i), 32'(seg_n), 32'(vec[i].exp_seg));
            check($sformatf("vec%0d dp_n", i), 32'(dp_n), 32'(vec[i].exp_dp_n));
            prev_an = vec[i].exp_an;
        end
        check("table ack count", 32'(ack_cnt - a0), 32'd4);

        // Two loads in one frame: latest wins, one ack.
        load_word(16'hAAAA, 4'b0000);
        repeat (2) @(negedge clk);
        load_word(16'h5555, 4'b0000);
        a0 = ack_cnt;
        do_strobe(4'b1000, 4'hE, 4'h7, 1'b1, "latest d3");
        check("latest d3 seg", 32'(seg_n), 32'h12);
        do_strobe(4'b0100, 4'h7, 4'hB, 1'b0, "latest d2");
        check("latest d2 seg", 32'(seg_n), 32'h12);
        do_strobe(4'b0010, 4'hB, 4'hD, 1'b0, "latest d1");
        do_strobe(4'b0001, 4'hD, 4'hE, 1'b0, "latest d0");
        check("latest d0 seg", 32'(seg_n), 32'h12);
        check("latest ack count", 32'(ack_cnt - a0), 32'd1);

        // Invalid strobe: error is sticky, return to 1000 is not a frame boundary.
        dig_sel = 4'b0110;
        repeat (4) @(negedge clk);
        check("inv sel_err", 32'(sel_err), 32'h1);
        check("inv an_n", 32'(an_n), 32'hF);
        check("inv seg_n", 32'(seg_n), 32'h7F);
        check("inv dp_n", 32'(dp_n), 32'h1);
        load_word(16'h8888, 4'b0000);
        a0 = ack_cnt;
        dig_sel = 4'b1000;
        repeat (8) @(negedge clk);
        check("recover an_n", 32'(an_n), 32'h7);
        check("recover seg_n old data", 32'(seg_n), 32'h12);
        check("recover sel_err sticky", 32'(sel_err), 32'h1);
        check("recover no ack", 32'(ack_cnt - a0), 32'd0);
        do_strobe(4'b0100, 4'h7, 4'hB, 1'b0, "rec d2");
        do_strobe(4'b0010, 4'hB, 4'hD, 1'b0, "rec d1");
        do_strobe(4'b0001, 4'hD, 4'hE, 1'b0, "rec d0");
        do_strobe(4'b1000, 4'hE, 4'h7, 1'b1, "rec d3");
        check("rec d3 seg new data", 32'(seg_n), 32'h00);
        check("rec sel_err still", 32'(sel_err), 32'h1);

        // Reset during dead time with a load pending.
        load_word(16'h3333, 4'b1111);
        dig_sel = 4'b0100;
        repeat (3) @(negedge clk);
        check("pre-clr an_n dead", 32'(an_n), 32'hF);
        clr_n = 1'b0;
        #1;
        check("clr sel_err", 32'(sel_err), 32'h0);
        check("clr an_n", 32'(an_n), 32'hF);
        check("clr seg_n", 32'(seg_n), 32'h7F);
        check("clr dp_n", 32'(dp_n), 32'h1);
        check("clr load_ack", 32'(load_ack), 32'h0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        a0 = ack_cnt;
        repeat (10) @(negedge clk);
        check("post-clr an_n", 32'(an_n), 32'hB);
        check("post-clr seg_n", 32'(seg_n), 32'h40);
        check("post-clr sel_err", 32'(sel_err), 32'h0);
        do_strobe(4'b0010, 4'hB, 4'hD, 1'b0, "pc d1");
        do_strobe(4'b0001, 4'hD, 4'hE, 1'b0, "pc d0");
        do_strobe(4'b1000, 4'hE, 4'h7, 1'b0, "pc d3");
        check("pc d3 seg zero", 32'(seg_n), 32'h40);
        check("pc d3 dp_n", 32'(dp_n), 32'h1);
        check("post-clr no ack", 32'(ack_cnt - a0), 32'd0);

        // Leading zeros: 0070.
        load_word(16'h0070, 4'b0000);
        do_strobe(4'b0100, 4'h7, 4'hB, 1'b0, "lz pre d2");
        do_strobe(4'b0010, 4'hB, 4'hD, 1'b0, "lz pre d1");
        do_strobe(4'b0001, 4'hD, 4'hE, 1'b0, "lz pre d0");
        do_strobe(4'b1000, 4'hE, 4'h7, 1'b1, "lz d3");
`ifdef SEG7_LZ_BLANK_EN
        check("lz d3 seg", 32'(seg_n), 32'h7F);
`else
        check("lz d3 seg", 32'(seg_n), 32'h40);
`endif
        do_strobe(4'b0100, 4'h7, 4'hB, 1'b0, "lz d2");
`ifdef SEG7_LZ_BLANK_EN
        check("lz d2 seg", 32'(seg_n), 32'h7F);
`else
        check("lz d2 seg", 32'(seg_n), 32'h40);
`endif
        check("lz d2 dp_n", 32'(dp_n), 32'h1);
        do_strobe(4'b0010, 4'hB, 4'hD, 1'b0, "lz d1");
        check("lz d1 seg", 32'(seg_n), 32'h78);
        do_strobe(4'b0001, 4'hD, 4'hE, 1'b0, "lz d0");
        check("lz d0 seg", 32'(seg_n), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_digit_mux.md
# seg7_digit_mux

Downstream consumer of the 4-bit one-hot ring-counter digit strobe. It drives a 4-digit common-anode seven-segment display from a 16-bit hex value. The strobe comes from a divided clock, so the block synchronises it into `clk` and inserts an anti-ghosting dead time at each digit change. Display data is updated only at frame boundaries, under a load/acknowledge handshake.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `dig_sel`; legal range 2..4.
- `DEAD_CYC`, default 2: `clk` cycles with all anodes off after each digit change; legal range 0..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `clr_n` in 1: asynchronous active-low reset.
- `dig_sel` in 4: one-hot digit strobe from the ring counter.
  - Sequence is 1000→0100→0010→0001→1000.
  - Asynchronous to `clk`.
- `data_in` in 16: four hex nibbles; `[15:12]` maps to `dig_sel[3]`, `[3:0]` to `dig_sel[0]`.
- `dp_in` in 4: decimal points, bit i belongs to digit i; 1 means lit.
- `load` in 1: single-cycle request to capture `data_in`/`dp_in`.
- `load_ack` out 1: one-cycle pulse when captured data becomes the shown data.
- `an_n` out 4: active-low anodes.
- `seg_n` out 7: active-low segments `{g,f,e,d,c,b,a}`.
- `dp_n` out 1: active-low decimal point.
- `sel_err` out 1: sticky flag, set when the synchronised strobe is not one-hot.

## Operation
- **Reset values:**
  - Outputs: `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `load_ack`=0, `sel_err`=0.
  - Internal: shown data=0, pending empty, synchroniser and previous-select registers=0.
- **Synchronisation:** `dig_sel` passes through `SYNC_STAGES` flops to give `sel_s`; `sel_p` holds the previous `sel_s`.
- **Sequencer FSM:**
  - States: SCAN, DEAD, INVALID.
  - SCAN: `an_n`=~`sel_s`; segments show the digit selected by `sel_s`.
  - SCAN→DEAD when `sel_s`≠`sel_p` and `sel_s` is one-hot. On that edge `an_n` goes to 4'hF, `seg_n` to 7'h7F, `dp_n` to 1, and the dead counter loads `DEAD_CYC`.
  - DEAD counts down. At zero it moves to SCAN, and new anode, segments and dp all update on the same edge. With `DEAD_CYC`=0, DEAD is skipped and SCAN updates directly.
  - Any state→INVALID when `sel_s` is not one-hot (including 0000). In INVALID, all outputs are off and `sel_err`=1, held until `clr_n`.
  - INVALID→DEAD when a one-hot `sel_s` returns.
- **Frame boundary:** a transition of `sel_s` to 4'b1000 from a different one-hot value. An entry from INVALID is not a boundary.
- **Load handshake:**
  - `load` copies `data_in`/`dp_in` into the pending register and sets pending-valid.
  - A further `load` while pending overwrites it (latest wins).
  - At a frame boundary with pending-valid: pending→shown, pending-valid cleared, `load_ack`=1 for exactly one cycle.
  - `load` on the boundary cycle: the old pending (if any) is applied now and the new data becomes pending for the next frame. With no old pending, nothing is applied and no ack is given this frame.
- **Decode (hex, active-low):**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **Reset mid-frame:** all state clears immediately (asynchronous). The display shows zeros from the first valid strobe after reset release.

## Timing
- `dig_sel` change → `sel_s` change: `SYNC_STAGES` edges.
- `sel_s` change → anodes off: 1 edge.
- Anodes off → new digit on: `DEAD_CYC` edges.
- Total for a new digit: `SYNC_STAGES`+1+`DEAD_CYC` edges; default 5.
- `load_ack` is asserted on the same edge that shown data updates, which is also the edge DEAD is entered at the boundary.
- All outputs are registered; no combinational path from inputs to outputs.
- The strobe period must exceed `SYNC_STAGES`+`DEAD_CYC`+2 `clk` cycles. Faster strobes are out of spec.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking. Digit i (i=3..1) is blanked (`seg_n`=7'h7F) when its nibble and all higher nibbles are zero. Digit 0 is always shown. `dp_n` is unaffected by blanking.
- Undefined: all four digits are always decoded.

## Structure
- Package `seg7_pkg`:
  - FSM state enum (SCAN, DEAD, INVALID).
  - Hex-to-segment constant table.
  - Blank constant 7'h7F.
  - Idle anode constant 4'hF.
  - One-hot check function.
- Sub-module `seg7_sync`: parameterised N-flop synchroniser with asynchronous active-low reset.

## Test plan
- Reset, then load 16'h1234 and run four strobes → digit 3 shows 79, digit 2 shows 24, digit 1 shows 30, digit 0 shows 19; `load_ack` pulses once at the first 1000.
- Measure dead time, default parameters → each `dig_sel` change gives `an_n`=F for exactly 2 cycles; the new anode appears 5 edges after the input change.
- Load 16'hAAAA, then 16'h5555, both mid-frame → only 5555 is shown after the boundary; exactly one `load_ack`.
- Drive `dig_sel`=0110 → `sel_err`=1 and `an_n`=F; restore a valid strobe → scanning resumes, `sel_err` stays 1 until `clr_n`.
- `SEG7_LZ_BLANK_EN` with data 16'h0070 → digit 3 is 7F, digit 2 is 7F, digit 1 is 78, digit 0 is 40; without the macro, digits 3 and 2 show 40.
- Assert `clr_n` low during DEAD with a pending load → outputs go to reset values immediately; no `load_ack` after release.
